instr_fetch: RTL and testbench

Instruction-fetch stage. It owns the program counter and drives a variable-latency instruction memory with a one-outstanding-request handshake. Fetched instructions go into a 2-entry fetch buffer, and the buffer head drives `PC_address_in`/`instr_in` of the IF/ID pipeline register. The stage honours the same hazard-unit stall as IF/ID and redirects to a new PC on a taken branch or jump.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: request FSM states,
// the bubble instruction and the instruction stride.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'b00,
    IF_WAIT    = 2'b01,
    IF_DISCARD = 2'b10
  } if_state_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry {pc, instr} fetch buffer. Entry 0 is always the head, so the
// head is read straight from a register with no read-pointer mux.
module fetch_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [63:0] din,
  output logic [63:0] head,
  output logic [1:0]  count
);

  logic [63:0] entry0;
  logic [63:0] entry1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload carries no reset; validity is qualified by count alone.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push && pop) begin
        if (count == 2'd2) begin
          entry0 <= entry1;
          entry1 <= din;
        end else begin
          entry0 <= din;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          entry0 <= din;
        end else begin
          entry1 <= din;
        end
      end else if (pop) begin
        entry0 <= entry1;
      end
    end
  end

  assign head = entry0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC ownership, one-outstanding-request memory
// handshake, redirect handling and a 2-entry buffer feeding IF/ID.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_stall,
  input  logic        is_redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_address_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  if_state_t   state;
  if_state_t   state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] target_pc;
  logic        push;
  logic        pop;
  logic        clear;
  logic        space;
  logic [1:0]  count;
  logic [63:0] head;

  assign target_pc   = redirect_pc & ~32'd3;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && !is_stall && !is_redirect;
  assign space       = (count - {1'b0, pop}) < 2'd2;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    clear      = 1'b0;
    case (state)
      IF_IDLE: begin
        if (is_redirect) begin
          clear   = 1'b1;
          pc_next = target_pc;
        end
        if (space) state_next = IF_WAIT;
      end
      IF_WAIT: begin
        if (is_redirect) begin
          clear      = 1'b1;
          pc_next    = target_pc;
          state_next = imem_ready ? IF_WAIT : IF_DISCARD;
        end else if (imem_ready) begin
          push    = 1'b1;
          pc_next = pc + INSTR_BYTES;
          if ((count + 2'd1 - {1'b0, pop}) == 2'd2) state_next = IF_IDLE;
        end
      end
      IF_DISCARD: begin
        // The stale request stays on the bus; only the target PC moves.
        if (is_redirect) begin
          clear   = 1'b1;
          pc_next = target_pc;
        end
        if (imem_ready) state_next = IF_WAIT;
      end
      default: state_next = IF_IDLE;
    endcase
  end

  // Address tracks the PC except while an abandoned request is still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      imem_req <= (state_next != IF_IDLE);
      if (state_next != IF_DISCARD) imem_addr <= pc_next;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   ({pc, imem_rdata}),
    .head  (head),
    .count (count)
  );

  assign PC_address_out = instr_valid ? head[63:32] : 32'd0;
  assign instr_out      = instr_valid ? head[31:0]  : BUBBLE_INSTR;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns {16'hC0DE, addr[15:0]}.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_stall;
  logic        is_redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_address_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .is_stall       (is_stall),
    .is_redirect    (is_redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .PC_address_out (PC_address_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; is_stall = 1'b0; is_redirect = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b1;
    #1;
    tests++;
    if ({imem_req, imem_addr, instr_valid, PC_address_out, instr_out} !== {1'b0, 32'h100, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: got req=%0b addr=%h v=%0b pc=%h instr=%h, want 0 00000100 0 0 0",
               imem_req, imem_addr, instr_valid, PC_address_out, instr_out);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    tick();
    tests++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
      fails++;
      $display("FAIL first_req: got req=%0b addr=%h v=%0b, want 1 00000100 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    tests++;
    if ({instr_valid, PC_address_out, instr_out, imem_addr} !== {1'b1, 32'h100, 32'hC0DE0100, 32'h104}) begin
      fails++;
      $display("FAIL first_instr: got v=%0b pc=%h instr=%h addr=%h, want 1 00000100 c0de0100 00000104",
               instr_valid, PC_address_out, instr_out, imem_addr);
    end
    tick();
    tests++;
    if ({instr_valid, PC_address_out, instr_out, imem_addr} !== {1'b1, 32'h104, 32'hC0DE0104, 32'h108}) begin
      fails++;
      $display("FAIL second_instr: got v=%0b pc=%h instr=%h addr=%h, want 1 00000104 c0de0104 00000108",
               instr_valid, PC_address_out, instr_out, imem_addr);
    end
  endtask

  task automatic test_stall();
    is_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({instr_valid, PC_address_out, imem_req} !== {1'b1, 32'h104, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h req=%0b, want 1 00000104 0",
                 i, instr_valid, PC_address_out, imem_req);
      end
    end
    is_stall = 1'b0;
    tick();
    tests++;
    if ({PC_address_out, instr_out, imem_req, imem_addr} !== {32'h108, 32'hC0DE0108, 1'b1, 32'h10C}) begin
      fails++;
      $display("FAIL stall_release: got pc=%h instr=%h req=%0b addr=%h, want 00000108 c0de0108 1 0000010c",
               PC_address_out, instr_out, imem_req, imem_addr);
    end
    tick();
    tests++;
    if ({instr_valid, PC_address_out} !== {1'b1, 32'h10C}) begin
      fails++;
      $display("FAIL stall_next: got v=%0b pc=%h, want 1 0000010c", instr_valid, PC_address_out);
    end
  endtask

  task automatic test_latency_redirect();
    imem_ready = 1'b0;
    tick();
    tests++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h110}) begin
      fails++;
      $display("FAIL lat_wait1: got v=%0b req=%0b addr=%h, want 0 1 00000110", instr_valid, imem_req, imem_addr);
    end
    is_redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    is_redirect = 1'b0;
    tests++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h110}) begin
      fails++;
      $display("FAIL lat_discard_hold: got v=%0b req=%0b addr=%h, want 0 1 00000110", instr_valid, imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    tests++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      fails++;
      $display("FAIL lat_dropped: got v=%0b req=%0b addr=%h, want 0 1 00000200", instr_valid, imem_req, imem_addr);
    end
    tick();
    tests++;
    if ({instr_valid, PC_address_out, instr_out} !== {1'b1, 32'h200, 32'hC0DE0200}) begin
      fails++;
      $display("FAIL lat_target: got v=%0b pc=%h instr=%h, want 1 00000200 c0de0200", instr_valid, PC_address_out, instr_out);
    end
  endtask

  task automatic test_redirect_same_cycle();
    is_redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    is_redirect = 1'b0;
    tests++;
    if ({imem_req, imem_addr, instr_valid, PC_address_out, instr_out} !== {1'b1, 32'h40, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL redir_ready: got req=%0b addr=%h v=%0b pc=%h instr=%h, want 1 00000040 0 0 0",
               imem_req, imem_addr, instr_valid, PC_address_out, instr_out);
    end
    tick();
    tests++;
    if ({instr_valid, PC_address_out, instr_out} !== {1'b1, 32'h40, 32'hC0DE0040}) begin
      fails++;
      $display("FAIL redir_target: got v=%0b pc=%h instr=%h, want 1 00000040 c0de0040", instr_valid, PC_address_out, instr_out);
    end
  endtask

  task automatic test_wrap();
    is_redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    is_redirect = 1'b0;
    tests++;
    if ({imem_addr, instr_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
      fails++;
      $display("FAIL wrap_addr: got addr=%h v=%0b, want fffffffc 0", imem_addr, instr_valid);
    end
    tick();
    tests++;
    if ({imem_addr, PC_address_out, instr_out} !== {32'h0, 32'hFFFF_FFFC, 32'hC0DE_FFFC}) begin
      fails++;
      $display("FAIL wrap_next: got addr=%h pc=%h instr=%h, want 00000000 fffffffc c0defffc",
               imem_addr, PC_address_out, instr_out);
    end
  endtask

  task automatic test_reset_mid();
    is_stall = 1'b1;
    tick();
    tests++;
    if ({instr_valid, imem_req} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL full_idle: got v=%0b req=%0b, want 1 0", instr_valid, imem_req);
    end
    is_stall = 1'b0; imem_ready = 1'b0;
    tick();
    tests++;
    if ({instr_valid, PC_address_out, imem_req, imem_addr} !== {1'b1, 32'h0, 1'b1, 32'h4}) begin
      fails++;
      $display("FAIL pre_reset: got v=%0b pc=%h req=%0b addr=%h, want 1 00000000 1 00000004",
               instr_valid, PC_address_out, imem_req, imem_addr);
    end
    is_stall = 1'b1; rst = 1'b1;
    #1;
    tests++;
    if ({imem_req, imem_addr, instr_valid, PC_address_out, instr_out} !== {1'b0, 32'h100, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL async_reset: got req=%0b addr=%h v=%0b pc=%h instr=%h, want 0 00000100 0 0 0",
               imem_req, imem_addr, instr_valid, PC_address_out, instr_out);
    end
    tick();
    rst = 1'b0; is_stall = 1'b0;
    tick();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      fails++;
      $display("FAIL restart_req: got req=%0b addr=%h, want 1 00000100", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    tests++;
    if ({instr_valid, PC_address_out, instr_out} !== {1'b1, 32'h100, 32'hC0DE0100}) begin
      fails++;
      $display("FAIL restart_instr: got v=%0b pc=%h instr=%h, want 1 00000100 c0de0100",
               instr_valid, PC_address_out, instr_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency_redirect();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
